sixteen_bit_sequential_divider: RTL and testbench

//   Iterative restoring divider, the inverse of the 16-bit Dadda multiplier.

---
 rtl/sixteen_bit_sequential_divider.sv | 109 ++++++++++
 tb/tb_sixteen_bit_sequential_divider.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/sixteen_bit_sequential_divider.sv
// Radix-2 restoring divider: 2*WIDTH-bit dividend by WIDTH-bit divisor, one quotient bit per clock.
// Divide-by-zero and quotient-overflow are resolved on the accept edge and skip iteration.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | waiting for start; outputs hold the last result
// S_RUN  | iterating, one quotient bit per clock (busy=1)
// S_DONE | result registers valid for this cycle (done=1); start accepted

module sixteen_bit_sequential_divider #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2*WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]     in2,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic                 div_by_zero,
  output logic                 overflow
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] rem_r, dvd_r, div_r;
  logic [WIDTH-1:0] rem_nxt, dvd_nxt;
  logic [WIDTH:0]   t;
  logic [CW-1:0]    cnt;
  logic             accept, exc_dz, exc_ov, last_step, ge;

  always_comb begin
    accept    = start && (state != S_RUN);
    exc_dz    = (in2 == '0);
    exc_ov    = !exc_dz && (in1[2*WIDTH-1:WIDTH] >= in2);
    last_step = (cnt == '0);
  end

  // One restoring step. Since rem_r < div_r, the difference fits in WIDTH bits,
  // so the low bits of the modular subtraction are the exact partial remainder.
  always_comb begin
    t       = {rem_r, dvd_r[WIDTH-1]};
    ge      = (t >= {1'b0, div_r});
    rem_nxt = ge ? (t[WIDTH-1:0] - div_r) : t[WIDTH-1:0];
    dvd_nxt = {dvd_r[WIDTH-2:0], ge};
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        done = (state == S_DONE);
        if (accept) state_nxt = (exc_dz || exc_ov) ? S_DONE : S_RUN;
        else        state_nxt = S_IDLE;
      end
      S_RUN: begin
        busy = 1'b1;
        if (last_step) state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Quotient bits shift into the vacated low end of the dividend register.
  always_ff @(posedge clk) begin
    if (rst) begin
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      rem_r       <= '0;
      dvd_r       <= '0;
      div_r       <= '0;
      cnt         <= '0;
    end else if (accept) begin
      div_by_zero <= exc_dz;
      overflow    <= exc_ov;
      if (exc_dz || exc_ov) begin
        quotient  <= '1;
        remainder <= in1[WIDTH-1:0];
      end
      rem_r <= in1[2*WIDTH-1:WIDTH];
      dvd_r <= in1[WIDTH-1:0];
      div_r <= in2;
      cnt   <= CW'(WIDTH - 1);
    end else if (state == S_RUN) begin
      rem_r <= rem_nxt;
      dvd_r <= dvd_nxt;
      cnt   <= cnt - CW'(1);
      if (last_step) begin
        quotient  <= dvd_nxt;
        remainder <= rem_nxt;
      end
    end
  end

endmodule

// File: tb/tb_sixteen_bit_sequential_divider.sv
// Directed and constructed-random checks of the sequential divider: latency,
// results, exception flags, start-while-busy, back-to-back start and mid-run reset.

module tb_sixteen_bit_sequential_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] in1 = '0;
  logic [15:0] in2 = '0;
  logic        busy, done, div_by_zero, overflow;
  logic [15:0] quotient, remainder;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int k_cyc = 0;
  int busy_cnt = 0;

  sixteen_bit_sequential_divider #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .in1(in1), .in2(in2),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (busy) busy_cnt++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [31:0] a, input logic [15:0] b);
    in1 = a;
    in2 = b;
    start = 1'b1;
    busy_cnt = 0;
    tick();
    k_cyc = cyc;
    start = 1'b0;
  endtask

  // Latency counts edges after the accept edge until done is seen.
  task automatic wait_done(input string tag, input int exp_lat, input int exp_busy);
    while (!done && (cyc - k_cyc) < 64) tick();
    check({tag, "_latency"}, 32'(cyc - k_cyc), 32'(exp_lat));
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
  endtask

  task automatic check_result(input string tag, input logic [15:0] q, input logic [15:0] r,
                              input logic dz, input logic ov);
    check({tag, "_quotient"}, 32'(quotient), 32'(q));
    check({tag, "_remainder"}, 32'(remainder), 32'(r));
    check({tag, "_div_by_zero"}, 32'(div_by_zero), 32'(dz));
    check({tag, "_overflow"}, 32'(overflow), 32'(ov));
  endtask

  initial begin
    int n_done;
    logic [15:0] rq, rd, rr;

    tick();
    tick();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check_result("reset", 16'd0, 16'd0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();

    start_op(32'd1000, 16'd7);
    wait_done("d1000_7", 16, 16);
    check_result("d1000_7", 16'd142, 16'd6, 1'b0, 1'b0);
    tick();
    check("done_pulse_drops", 32'(done), 32'd0);

    start_op(32'hFFFE_0001, 16'hFFFF);
    wait_done("max_prod", 16, 16);
    check_result("max_prod", 16'hFFFF, 16'd0, 1'b0, 1'b0);
    tick();

    start_op(32'h0000_FFFF, 16'd1);
    wait_done("div_one", 16, 16);
    check_result("div_one", 16'hFFFF, 16'd0, 1'b0, 1'b0);
    tick();

    start_op(32'd123, 16'd0);
    wait_done("dbz", 0, 0);
    check_result("dbz", 16'hFFFF, 16'd123, 1'b1, 1'b0);
    tick();

    start_op(32'h0001_0000, 16'd1);
    wait_done("ovf", 0, 0);
    check_result("ovf", 16'hFFFF, 16'd0, 1'b0, 1'b1);
    tick();

    start_op(32'd1000, 16'd7);
    check("flags_clear_on_accept", 32'({div_by_zero, overflow}), 32'd0);
    repeat (5) tick();
    check("hold_during_run", 32'(quotient), 32'hFFFF);
    wait_done("after_ovf", 16, 16);
    check_result("after_ovf", 16'd142, 16'd6, 1'b0, 1'b0);
    tick();

    start_op(32'd1000, 16'd7);
    repeat (7) tick();
    in1 = 32'd5000;
    in2 = 16'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("ignore_start", 16, 16);
    check_result("ignore_start", 16'd142, 16'd6, 1'b0, 1'b0);

    start_op(32'd5000, 16'd9);
    check("b2b_done_drops", 32'(done), 32'd0);
    check("b2b_busy", 32'(busy), 32'd1);
    wait_done("b2b", 16, 16);
    check_result("b2b", 16'd555, 16'd5, 1'b0, 1'b0);
    tick();

    start_op(32'd5000, 16'd9);
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check_result("midrst", 16'd0, 16'd0, 1'b0, 1'b0);
    n_done = 0;
    repeat (24) begin
      tick();
      if (done) n_done++;
    end
    check("midrst_no_done", 32'(n_done), 32'd0);

    for (int i = 0; i < 200; i++) begin
      rd = 16'($urandom_range(1, 65535));
      rq = 16'($urandom_range(0, 65535));
      rr = 16'($urandom % 32'(rd));
      start_op(32'(rq) * 32'(rd) + 32'(rr), rd);
      while (!done && (cyc - k_cyc) < 64) tick();
      check("rand_quotient", 32'(quotient), 32'(rq));
      check("rand_remainder", 32'(remainder), 32'(rr));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
